mem_arbiter: RTL

- Two-client arbiter directly upstream of the external memory port.
- Multiplexes the instruction-fetch client (c0, read-only) and the data client (c1, read/write) onto the single memory request / write-data / response channel set.
- One memory transaction in flight at a time; read responses are steered back to the client that owns the transaction.
- The memory returns each read as DATA_CYCLES consecutive response beats; each write is one address handshake followed by one data-beat handshake.

---
 rtl/mem_arb_pkg.sv | 44 ++++
 rtl/mem_arbiter_if.sv | 75 +++++++
 rtl/mem_arb_picker.sv | 42 ++++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared widths, FSM state encoding and client ids for the
//            two-client memory arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    // Memory channel geometry (address counts 128-bit words)
    localparam int MEM_ADDR_BITS = 28;
    localparam int MEM_DATA_BITS = 128;
    localparam int MEM_TAG_BITS  = 5;
    localparam int MEM_MASK_BITS = MEM_DATA_BITS / 8;

    // Read response beats returned per read transaction
    localparam int DATA_CYCLES   = 4;

    // Smallest r such that 2**r >= value
    function automatic int ceil_log2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Beat counter keeps at least one bit so DATA_CYCLES = 1 still builds
    localparam int BEAT_CNT_BITS = (ceil_log2(DATA_CYCLES) < 1) ? 1 : ceil_log2(DATA_CYCLES);

    // Arbiter FSM encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RD   = 2'd1;
    localparam logic [1:0] c_ST_WR   = 2'd2;

    // Client ids; also the bit index of each client in a grant vector
    localparam logic c_CLIENT_IFETCH = 1'b0;
    localparam logic c_CLIENT_DATA   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module   : mem_arbiter_if
// Brief    : Bundle of the two client channels and the memory channel.
//            master = the arbiter's view, slave = clients plus memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if;
    import mem_arb_pkg::*;

    // c0: instruction fetch, read only
    logic                     c0_req_valid;
    logic                     c0_req_ready;
    logic [MEM_ADDR_BITS-1:0] c0_req_addr;
    logic [MEM_TAG_BITS-1:0]  c0_req_tag;
    logic                     c0_resp_valid;
    logic [MEM_DATA_BITS-1:0] c0_resp_data;
    logic [MEM_TAG_BITS-1:0]  c0_resp_tag;

    // c1: data client, read/write
    logic                     c1_req_valid;
    logic                     c1_req_ready;
    logic                     c1_req_rw;
    logic [MEM_ADDR_BITS-1:0] c1_req_addr;
    logic [MEM_TAG_BITS-1:0]  c1_req_tag;
    logic                     c1_data_valid;
    logic                     c1_data_ready;
    logic [MEM_DATA_BITS-1:0] c1_data_bits;
    logic [MEM_MASK_BITS-1:0] c1_data_mask;
    logic                     c1_resp_valid;
    logic [MEM_DATA_BITS-1:0] c1_resp_data;
    logic [MEM_TAG_BITS-1:0]  c1_resp_tag;

    // Memory port
    logic                     mem_req_valid;
    logic                     mem_req_ready;
    logic                     mem_req_rw;
    logic [MEM_ADDR_BITS-1:0] mem_req_addr;
    logic [MEM_TAG_BITS-1:0]  mem_req_tag;
    logic                     mem_req_data_valid;
    logic                     mem_req_data_ready;
    logic [MEM_DATA_BITS-1:0] mem_req_data_bits;
    logic [MEM_MASK_BITS-1:0] mem_req_data_mask;
    logic                     mem_resp_valid;
    logic [MEM_DATA_BITS-1:0] mem_resp_data;
    logic [MEM_TAG_BITS-1:0]  mem_resp_tag;

    modport master (
        input  c0_req_valid, c0_req_addr, c0_req_tag,
        output c0_req_ready, c0_resp_valid, c0_resp_data, c0_resp_tag,
        input  c1_req_valid, c1_req_rw, c1_req_addr, c1_req_tag,
        input  c1_data_valid, c1_data_bits, c1_data_mask,
        output c1_req_ready, c1_data_ready, c1_resp_valid, c1_resp_data, c1_resp_tag,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
        output mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        input  mem_req_ready, mem_req_data_ready,
        input  mem_resp_valid, mem_resp_data, mem_resp_tag
    );

    modport slave (
        output c0_req_valid, c0_req_addr, c0_req_tag,
        input  c0_req_ready, c0_resp_valid, c0_resp_data, c0_resp_tag,
        output c1_req_valid, c1_req_rw, c1_req_addr, c1_req_tag,
        output c1_data_valid, c1_data_bits, c1_data_mask,
        input  c1_req_ready, c1_data_ready, c1_resp_valid, c1_resp_data, c1_resp_tag,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
        input  mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        output mem_req_ready, mem_req_data_ready,
        output mem_resp_valid, mem_resp_data, mem_resp_tag
    );

endinterface

`default_nettype wire

// File: rtl/mem_arb_picker.sv
// ============================================================================
// Module   : mem_arb_picker
// Brief    : Combinational two-way grant. One-hot output indexed by client
//            id. Conflict rule selected by macro MEM_ARB_ROUND_ROBIN_EN:
//            defined   -> grant the client that did not win last time,
//            undefined -> the data client (c1) always wins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_picker
    import mem_arb_pkg::*;
(
    input  wire logic [1:0] i_valid,
    input  wire logic       i_last_grant,
    output logic      [1:0] o_grant
);

    logic w_conflict_to_data;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Alternate under contention: whoever was not served last goes next
    assign w_conflict_to_data = (i_last_grant != c_CLIENT_DATA);
`else
    // Fixed priority: last_grant is still tracked upstream but cannot steer
    assign w_conflict_to_data = i_last_grant | 1'b1;
`endif

    // Single requester wins outright; a conflict is resolved by the rule above
    always_comb begin
        o_grant = 2'b00;
        case (i_valid)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = w_conflict_to_data ? 2'b10 : 2'b01;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-client arbiter in front of the external memory port.
//            c0 (ifetch, read only) and c1 (data, read/write) share one
//            request / write-data / response channel set, one transaction
//            in flight at a time. Optional round-robin conflict resolution
//            via macro MEM_ARB_ROUND_ROBIN_EN (default: c1 has priority).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
(
    input  wire logic     clk,
    input  wire logic     reset,
    mem_arbiter_if.master bus
);

    localparam logic [BEAT_CNT_BITS-1:0] c_LAST_BEAT = BEAT_CNT_BITS'(DATA_CYCLES - 1);
    localparam logic [BEAT_CNT_BITS-1:0] c_BEAT_ONE  = BEAT_CNT_BITS'(1);

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic                     r_owner;
    logic                     w_owner_nxt;
    logic [BEAT_CNT_BITS-1:0] r_beat_cnt;
    logic [BEAT_CNT_BITS-1:0] w_beat_cnt_nxt;
    logic                     r_last_grant;
    logic                     w_last_grant_nxt;

    logic [1:0]               w_grant;
    logic                     w_sel_data;
    logic                     w_addr_hs;
    logic                     w_data_hs;

    mem_arb_picker u_picker (
        .i_valid      ({bus.c1_req_valid, bus.c0_req_valid}),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    assign w_sel_data = w_grant[c_CLIENT_DATA];
    assign w_addr_hs  = bus.mem_req_valid & bus.mem_req_ready;
    assign w_data_hs  = bus.mem_req_data_valid & bus.mem_req_data_ready;

    // State register; reset abandons any in-flight transaction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= c_ST_IDLE;
            r_owner      <= c_CLIENT_IFETCH;
            r_beat_cnt   <= '0;
            r_last_grant <= c_CLIENT_DATA;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_beat_cnt   <= w_beat_cnt_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    // Next state: grant on address handshake, count read beats, wait for write beat
    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_beat_cnt_nxt   = r_beat_cnt;
        w_last_grant_nxt = r_last_grant;
        case (r_state)
            c_ST_IDLE: begin
                if (w_addr_hs) begin
                    w_owner_nxt      = w_sel_data;
                    w_last_grant_nxt = w_sel_data;
                    w_beat_cnt_nxt   = '0;
                    w_state_nxt      = bus.mem_req_rw ? c_ST_WR : c_ST_RD;
                end
            end
            c_ST_RD: begin
                if (bus.mem_resp_valid) begin
                    if (r_beat_cnt == c_LAST_BEAT) begin
                        w_beat_cnt_nxt = '0;
                        w_state_nxt    = c_ST_IDLE;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + c_BEAT_ONE;
                    end
                end
            end
            c_ST_WR: begin
                if (w_data_hs) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Outputs: address mux, ready steering, response routing; handshakes held low in reset
    always_comb begin
        bus.mem_req_rw         = w_sel_data & bus.c1_req_rw;
        bus.mem_req_addr       = w_sel_data ? bus.c1_req_addr : bus.c0_req_addr;
        bus.mem_req_tag        = w_sel_data ? bus.c1_req_tag  : bus.c0_req_tag;
        bus.mem_req_data_bits  = bus.c1_data_bits;
        bus.mem_req_data_mask  = bus.c1_data_mask;
        bus.c0_resp_data       = bus.mem_resp_data;
        bus.c0_resp_tag        = bus.mem_resp_tag;
        bus.c1_resp_data       = bus.mem_resp_data;
        bus.c1_resp_tag        = bus.mem_resp_tag;

        bus.mem_req_valid      = 1'b0;
        bus.c0_req_ready       = 1'b0;
        bus.c1_req_ready       = 1'b0;
        bus.mem_req_data_valid = 1'b0;
        bus.c1_data_ready      = 1'b0;
        bus.c0_resp_valid      = 1'b0;
        bus.c1_resp_valid      = 1'b0;

        if (reset) begin
            case (r_state)
                c_ST_IDLE: begin
                    bus.mem_req_valid = |w_grant;
                    bus.c0_req_ready  = w_grant[c_CLIENT_IFETCH] & bus.mem_req_ready;
                    bus.c1_req_ready  = w_grant[c_CLIENT_DATA]   & bus.mem_req_ready;
                end
                c_ST_RD: begin
                    bus.c0_resp_valid = bus.mem_resp_valid & (r_owner == c_CLIENT_IFETCH);
                    bus.c1_resp_valid = bus.mem_resp_valid & (r_owner == c_CLIENT_DATA);
                end
                c_ST_WR: begin
                    bus.mem_req_data_valid = bus.c1_data_valid;
                    bus.c1_data_ready      = bus.mem_req_data_ready;
                end
                default: begin
                    bus.mem_req_valid = 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
